// File: rtl/bus_responder.sv
// Target-side responder for the 65C02 bus: zero-wait internal RAM, one I/O page
// bridged to a req/ack peripheral port with a timeout guard, open bus elsewhere.
module bus_responder #(
  parameter int          RAM_AW  = 9,
  parameter logic [7:0]  IO_PAGE = 8'hD0,
  parameter int          TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] AB,
  input  logic        WE,
  input  logic [7:0]  DO,
  output logic [7:0]  DI,
  output logic        RDY,
  output logic        io_req,
  output logic        io_we,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_wdata,
  input  logic [7:0]  io_rdata,
  input  logic        io_ack,
  output logic        io_err,
  input  logic        io_err_clr
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    IO_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  state_t      state_r;
  logic [7:0]  count_r;
  logic [7:0]  ram_r [2**RAM_AW];
  logic [7:0]  ram_rd_s;
  logic        accept_s;
  logic        ram_hit_s;
  logic        io_hit_s;

  // RAM wins over the I/O page when the two ranges overlap.
  assign ram_hit_s = ((AB >> RAM_AW) == 16'd0);
  assign io_hit_s  = !ram_hit_s && (AB[15:8] == IO_PAGE);
  assign accept_s  = (state_r == IDLE) && RDY;
  assign ram_rd_s  = ram_r[AB[RAM_AW-1:0]];

  // RAM write port; contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (reset_n && accept_s && ram_hit_s && WE) begin
      ram_r[AB[RAM_AW-1:0]] <= DO;
    end
  end

  // Access decode, peripheral handshake, timeout and sticky error flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      count_r  <= 8'd0;
      DI       <= 8'h00;
      RDY      <= 1'b1;
      io_req   <= 1'b0;
      io_we    <= 1'b0;
      io_addr  <= 8'h00;
      io_wdata <= 8'h00;
      io_err   <= 1'b0;
    end else begin
      if (io_err_clr) begin
        io_err <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (RDY) begin
            if (ram_hit_s) begin
              if (!WE) begin
                DI <= ram_rd_s;
              end
            end else if (io_hit_s) begin
              state_r  <= IO_WAIT;
              RDY      <= 1'b0;
              io_req   <= 1'b1;
              io_we    <= WE;
              io_addr  <= AB[7:0];
              io_wdata <= DO;
              count_r  <= 8'd0;
            end else if (!WE) begin
              DI <= 8'hFF;
            end
          end
        end
        IO_WAIT: begin
          // AB/WE are held by the stalled CPU, so the captured io_we still
          // tells us whether the access is a read.
          if (io_ack) begin
            state_r <= IDLE;
            RDY     <= 1'b1;
            io_req  <= 1'b0;
            io_we   <= 1'b0;
            if (!io_we) begin
              DI <= io_rdata;
            end
          end else if (count_r == LAST_COUNT) begin
            state_r <= IDLE;
            RDY     <= 1'b1;
            io_req  <= 1'b0;
            io_we   <= 1'b0;
            io_err  <= 1'b1;
            if (!io_we) begin
              DI <= 8'hFF;
            end
          end else begin
            count_r <= count_r + 8'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          RDY     <= 1'b1;
          io_req  <= 1'b0;
          io_we   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
// Directed self-checking bench for bus_responder; read data expectations flow
// through a scoreboard queue filled when an access is driven.
module tb_bus_responder;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        reset_n;
  logic [15:0] AB;
  logic        WE;
  logic [7:0]  DO;
  logic [7:0]  DI;
  logic        RDY;
  logic        io_req;
  logic        io_we;
  logic [7:0]  io_addr;
  logic [7:0]  io_wdata;
  logic [7:0]  io_rdata;
  logic        io_ack;
  logic        io_err;
  logic        io_err_clr;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  sb[$];
  logic [7:0]  last_di;

  bus_responder #(.RAM_AW(9), .IO_PAGE(8'hD0), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .AB(AB), .WE(WE), .DO(DO), .DI(DI), .RDY(RDY),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ack(io_ack), .io_err(io_err), .io_err_clr(io_err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    logic [7:0] exp;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed %h expected <scoreboard empty>", tag, DI);
    end else begin
      exp = sb.pop_front();
      chk(tag, {8'h00, DI}, {8'h00, exp});
    end
  endtask

  task automatic ram_or_open(input string tag, input logic [15:0] addr, input logic we,
                             input logic [7:0] d, input logic [7:0] exp_rd);
    AB = addr; WE = we; DO = d;
    if (!we) last_di = exp_rd;
    sb.push_back(last_di);
    cycle();
    sb_check(tag);
    chk({tag, "_rdy"}, {15'd0, RDY}, 16'd1);
  endtask

  task automatic io_access(input string tag, input logic [15:0] addr, input logic we,
                           input logic [7:0] d, input int ack_at, input logic [7:0] rdata);
    int low;
    int exp_low;
    AB = addr; WE = we; DO = d; io_rdata = rdata;
    exp_low = (ack_at >= 1 && ack_at <= TIMEOUT) ? ack_at : TIMEOUT;
    if (!we) last_di = (ack_at >= 1 && ack_at <= TIMEOUT) ? rdata : 8'hFF;
    sb.push_back(last_di);
    cycle();
    chk({tag, "_req"}, {15'd0, io_req}, 16'd1);
    chk({tag, "_addr"}, {8'h00, io_addr}, {8'h00, addr[7:0]});
    chk({tag, "_we"}, {15'd0, io_we}, {15'd0, we});
    if (we) chk({tag, "_wdata"}, {8'h00, io_wdata}, {8'h00, d});
    low = 1;
    for (int k = 1; k <= 300; k++) begin
      io_ack = (k == ack_at);
      cycle();
      io_ack = 1'b0;
      if (RDY) break;
      low++;
    end
    chk({tag, "_rdy_low"}, 16'(low), 16'(exp_low));
    chk({tag, "_req_drop"}, {15'd0, io_req}, 16'd0);
    sb_check({tag, "_di"});
  endtask

  initial begin
    reset_n = 1'b0; AB = 16'h8000; WE = 1'b0; DO = 8'h00;
    io_rdata = 8'h00; io_ack = 1'b0; io_err_clr = 1'b0; last_di = 8'h00;
    @(negedge clk);
    cycle();
    chk("rst_di", {8'h00, DI}, 16'h0000);
    chk("rst_rdy", {15'd0, RDY}, 16'd1);
    chk("rst_req", {15'd0, io_req}, 16'd0);
    chk("rst_we", {15'd0, io_we}, 16'd0);
    chk("rst_addr", {8'h00, io_addr}, 16'h0000);
    chk("rst_wdata", {8'h00, io_wdata}, 16'h0000);
    chk("rst_err", {15'd0, io_err}, 16'd0);
    reset_n = 1'b1;

    // RAM top byte, zero page, unmapped read and an unmapped write
    ram_or_open("ram_wr_1ff", 16'h01FF, 1'b1, 8'h5A, 8'h00);
    ram_or_open("ram_rd_1ff", 16'h01FF, 1'b0, 8'h00, 8'h5A);
    ram_or_open("ram_wr_000", 16'h0000, 1'b1, 8'h3C, 8'h00);
    ram_or_open("ram_rd_000", 16'h0000, 1'b0, 8'h00, 8'h3C);
    ram_or_open("open_rd", 16'h8000, 1'b0, 8'h00, 8'hFF);
    ram_or_open("open_wr", 16'h8000, 1'b1, 8'h11, 8'h00);
    ram_or_open("ram_after_open", 16'h01FF, 1'b0, 8'h00, 8'h5A);
    ram_or_open("ram_alias_200", 16'h0200, 1'b0, 8'h00, 8'hFF);

    // idle-time ack must be ignored
    io_ack = 1'b1;
    ram_or_open("idle_ack", 16'h0000, 1'b0, 8'h00, 8'h3C);
    io_ack = 1'b0;
    chk("idle_ack_req", {15'd0, io_req}, 16'd0);

    io_access("io_rd3", 16'hD012, 1'b0, 8'h00, 3, 8'hC3);
    io_access("io_wr1", 16'hD0FF, 1'b1, 8'h77, 1, 8'h00);
    chk("io_wr_noerr", {15'd0, io_err}, 16'd0);

    io_access("io_tmo", 16'hD034, 1'b0, 8'h00, 0, 8'h99);
    chk("tmo_err", {15'd0, io_err}, 16'd1);
    io_err_clr = 1'b1;
    ram_or_open("err_clr", 16'h8000, 1'b0, 8'h00, 8'hFF);
    io_err_clr = 1'b0;
    chk("err_cleared", {15'd0, io_err}, 16'd0);

    io_access("io_ack16", 16'hD034, 1'b0, 8'h00, 16, 8'hA5);
    chk("ack16_noerr", {15'd0, io_err}, 16'd0);

    io_err_clr = 1'b1;
    io_access("io_tmo_clr", 16'hD001, 1'b1, 8'h42, 0, 8'h00);
    io_err_clr = 1'b0;
    chk("set_beats_clr", {15'd0, io_err}, 16'd1);

    // reset in the middle of a wait aborts cleanly
    AB = 16'hD012; WE = 1'b0;
    cycle();
    chk("mid_rdy_low", {15'd0, RDY}, 16'd0);
    cycle();
    cycle();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1; AB = 16'h8000;
    chk("mid_rst_rdy", {15'd0, RDY}, 16'd1);
    chk("mid_rst_req", {15'd0, io_req}, 16'd0);
    chk("mid_rst_err", {15'd0, io_err}, 16'd0);
    chk("mid_rst_di", {8'h00, DI}, 16'h0000);
    io_ack = 1'b1; io_rdata = 8'h5B;
    cycle();
    io_ack = 1'b0;
    chk("late_ack_rdy", {15'd0, RDY}, 16'd1);
    chk("late_ack_req", {15'd0, io_req}, 16'd0);
    chk("late_ack_di", {8'h00, DI}, 16'h00FF);
    chk("late_ack_err", {15'd0, io_err}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
